id_stage_hz: RTL and testbench

Parametrised decode stage for the 5-stage MIPS pipeline. It holds the IF/ID pipeline register and adds stall/flush control, a valid bit, and load-use hazard detection. It forwards operands from EX/MEM/WB, extends immediates, resolves BEQ/BNE early, and keeps a saturating stall counter. It sits between IF and EX; the register file is instantiated inside it.

---
 rtl/id_stage_hz_pkg.sv | 21 ++
 rtl/id_stage_hz_regfile_bypass.sv | 38 +++
 rtl/id_stage_hz.sv | 122 ++++++++++++
 tb/tb_id_stage_hz.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/id_stage_hz_pkg.sv
// Shared decode constants for the ID stage: opcodes, NOP encoding, instruction
// field positions, and a helper that classifies zero-extending immediates.
package id_stage_hz_pkg;
   localparam logic [5:0]  OP_BEQ   = 6'h04;
   localparam logic [5:0]  OP_BNE   = 6'h05;
   localparam logic [5:0]  OP_ANDI  = 6'h0C;
   localparam logic [5:0]  OP_ORI   = 6'h0D;
   localparam logic [5:0]  OP_XORI  = 6'h0E;
   localparam logic [31:0] INST_NOP = 32'h0;

   localparam int OP_LSB = 26;
   localparam int RS_LSB = 21;
   localparam int RT_LSB = 16;
   localparam int RD_LSB = 11;
   localparam int IMM_W  = 16;

   // Logical immediates are zero-extended; everything else sign-extends.
   function automatic logic is_zext(input logic [5:0] op);
      return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
   endfunction
endpackage

// File: rtl/id_stage_hz_regfile_bypass.sv
// NREG x DW register file: two operand read ports, one debug read port, one
// write port. R0 is never written, so it always reads zero. Reads return the
// stored value only; same-cycle WB data is supplied by the forwarding mux in
// the parent, not here.
// Ports: clk, rst (async, active-low), ra_a/ra_b/ra_dbg read addresses,
//        rd_a/rd_b/rd_dbg read data, we/wa/wd write port.
module regfile_bypass #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] ra_a,
   input  logic [AW-1:0] ra_b,
   input  logic [AW-1:0] ra_dbg,
   output logic [DW-1:0] rd_a,
   output logic [DW-1:0] rd_b,
   output logic [DW-1:0] rd_dbg,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd
);
   localparam int NREG = 2**AW;

   logic [NREG-1:0][DW-1:0] regs;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (we && wa != '0) begin
         regs[wa] <= wd;
      end
   end

   assign rd_a   = regs[ra_a];
   assign rd_b   = regs[ra_b];
   assign rd_dbg = regs[ra_dbg];
endmodule

// File: rtl/id_stage_hz.sv
// Decode stage of the 5-stage MIPS pipeline: IF/ID register with flush/stall
// control, load-use hazard detection, EX/MEM/WB operand forwarding, immediate
// extension, early BEQ/BNE resolution and a saturating stall counter.
// Ports: clk, rst (async, active-low); IF side if_valid/if_inst/if_pc4;
//        control ext_stall/flush; EX/MEM/WB writeback info for forwarding and
//        regfile writes; which_reg/reg_content debug read; decoded outputs
//        id_*, rs/rt/rd, hazard_stall, br_taken/br_target, stall_cnt.
module id_stage_hz
   import id_stage_hz_pkg::*;
#(
   parameter int          DW        = 32,
   parameter int          AW        = 5,
   parameter logic [DW-1:0] RESET_PC4 = '0,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_valid,
   input  logic [31:0]      if_inst,
   input  logic [DW-1:0]    if_pc4,
   input  logic             ext_stall,
   input  logic             flush,
   input  logic             ex_wreg,
   input  logic             ex_m2reg,
   input  logic [AW-1:0]    ex_destR,
   input  logic [DW-1:0]    ex_alu,
   input  logic             mem_wreg,
   input  logic [AW-1:0]    mem_destR,
   input  logic [DW-1:0]    mem_data,
   input  logic             wb_wreg,
   input  logic [AW-1:0]    wb_destR,
   input  logic [DW-1:0]    wb_dest,
   input  logic [AW-1:0]    which_reg,
   output logic [DW-1:0]    reg_content,
   output logic [31:0]      id_inst,
   output logic [DW-1:0]    id_pc4,
   output logic             id_valid,
   output logic [DW-1:0]    id_inA,
   output logic [DW-1:0]    id_inB,
   output logic [DW-1:0]    id_imm,
   output logic [AW-1:0]    rs,
   output logic [AW-1:0]    rt,
   output logic [AW-1:0]    rd,
   output logic             hazard_stall,
   output logic             br_taken,
   output logic [DW-1:0]    br_target,
   output logic [CNT_W-1:0] stall_cnt
);
   logic [31:0]      inst_q;
   logic [DW-1:0]    pc4_q;
   logic             valid_q;
   logic [CNT_W-1:0] cnt_q;
   logic [DW-1:0]    rf_a, rf_b;
   logic             stall, cmp;
   logic [5:0]       op;
   logic [IMM_W-1:0] imm16;

   assign op    = inst_q[OP_LSB +: 6];
   assign imm16 = inst_q[IMM_W-1:0];
   assign rs    = inst_q[RS_LSB +: AW];
   assign rt    = inst_q[RT_LSB +: AW];
   assign rd    = inst_q[RD_LSB +: AW];

   regfile_bypass #(.DW(DW), .AW(AW)) u_rf (
      .clk(clk), .rst(rst),
      .ra_a(rs), .ra_b(rt), .ra_dbg(which_reg),
      .rd_a(rf_a), .rd_b(rf_b), .rd_dbg(reg_content),
      .we(wb_wreg), .wa(wb_destR), .wd(wb_dest)
   );

   // A load in EX cannot forward yet, so it is excluded from the EX match and
   // instead raises the load-use stall.
   assign hazard_stall = valid_q && ex_wreg && ex_m2reg && (ex_destR != '0) &&
                         ((ex_destR == rs) || (ex_destR == rt));
   assign stall        = hazard_stall || ext_stall;

   function automatic logic [DW-1:0] fwd(input logic [AW-1:0] src, input logic [DW-1:0] rf);
      if (src == '0)                                return '0;
      else if (ex_wreg && !ex_m2reg && ex_destR == src) return ex_alu;
      else if (mem_wreg && mem_destR == src)        return mem_data;
      else if (wb_wreg && wb_destR == src)          return wb_dest;
      else                                          return rf;
   endfunction

   assign id_inA = fwd(rs, rf_a);
   assign id_inB = fwd(rt, rf_b);
   assign id_imm = is_zext(op) ? {{(DW-IMM_W){1'b0}}, imm16}
                               : {{(DW-IMM_W){imm16[IMM_W-1]}}, imm16};

   always_comb begin
      cmp = 1'b0;
      if (op == OP_BEQ)      cmp = (id_inA == id_inB);
      else if (op == OP_BNE) cmp = (id_inA != id_inB);
   end

   assign br_taken  = valid_q && !hazard_stall && cmp;
   assign br_target = pc4_q + (id_imm << 2);

   // Priority: flush > stall > load. A flush also blocks the counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inst_q  <= INST_NOP;
         pc4_q   <= RESET_PC4;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else if (flush) begin
         inst_q  <= INST_NOP;
         valid_q <= 1'b0;
      end else if (stall) begin
         if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      end else begin
         inst_q  <= if_inst;
         pc4_q   <= if_pc4;
         valid_q <= if_valid;
      end
   end

   assign id_inst   = inst_q;
   assign id_pc4    = pc4_q;
   assign id_valid  = valid_q && !hazard_stall;
   assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_id_stage_hz.sv
module tb_id_stage_hz;
   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid, ext_stall, flush;
   logic [31:0] if_inst, if_pc4;
   logic        ex_wreg, ex_m2reg, mem_wreg, wb_wreg;
   logic [4:0]  ex_destR, mem_destR, wb_destR, which_reg;
   logic [31:0] ex_alu, mem_data, wb_dest;
   logic [31:0] reg_content, id_inst, id_pc4, id_inA, id_inB, id_imm, br_target;
   logic        id_valid, hazard_stall, br_taken;
   logic [4:0]  rs, rt, rd;
   logic [1:0]  stall_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   id_stage_hz #(.DW(32), .AW(5), .RESET_PC4(32'h40), .CNT_W(2)) dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc4(if_pc4),
      .ext_stall(ext_stall), .flush(flush),
      .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_destR(ex_destR), .ex_alu(ex_alu),
      .mem_wreg(mem_wreg), .mem_destR(mem_destR), .mem_data(mem_data),
      .wb_wreg(wb_wreg), .wb_destR(wb_destR), .wb_dest(wb_dest),
      .which_reg(which_reg), .reg_content(reg_content),
      .id_inst(id_inst), .id_pc4(id_pc4), .id_valid(id_valid),
      .id_inA(id_inA), .id_inB(id_inB), .id_imm(id_imm),
      .rs(rs), .rt(rt), .rd(rd), .hazard_stall(hazard_stall),
      .br_taken(br_taken), .br_target(br_target), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fwd_idle();
      ex_wreg = 0; ex_m2reg = 0; ex_destR = 0; ex_alu = 0;
      mem_wreg = 0; mem_destR = 0; mem_data = 0;
      wb_wreg = 0; wb_destR = 0; wb_dest = 0;
   endtask

   typedef struct {
      logic [31:0] inst;
      logic        ex_w;  logic [4:0] ex_d;  logic [31:0] ex_v;
      logic        mem_w; logic [4:0] mem_d; logic [31:0] mem_v;
      logic        wb_w;  logic [4:0] wb_d;  logic [31:0] wb_v;
      logic [31:0] e_a, e_b, e_imm;
      logic        e_br;
      logic [31:0] e_tgt;
   } vec_t;

   vec_t vec [12];

   initial begin
      // All table vectors use pc4 = 0x100; R2=0x22 and R5=0x55 are preloaded.
      vec[0]  = '{32'h20010005, 0,0,0,        0,0,0,        0,0,0,        32'h0,  32'h0,  32'h5,        0, 32'h114};
      vec[1]  = '{32'h00821820, 1,4,32'hA,    1,4,32'hB,    1,4,32'hC,    32'hA,  32'h22, 32'h1820,     0, 32'h6180};
      vec[2]  = '{32'h00821820, 0,4,32'hA,    1,4,32'hB,    1,4,32'hC,    32'hB,  32'h22, 32'h1820,     0, 32'h6180};
      vec[3]  = '{32'h00821820, 0,4,32'hA,    0,4,32'hB,    1,4,32'hC,    32'hC,  32'h22, 32'h1820,     0, 32'h6180};
      vec[4]  = '{32'h00821820, 0,4,32'hA,    0,4,32'hB,    0,4,32'hC,    32'h0,  32'h22, 32'h1820,     0, 32'h6180};
      vec[5]  = '{32'h1042FFFF, 0,0,0,        0,0,0,        0,0,0,        32'h22, 32'h22, 32'hFFFFFFFF, 1, 32'hFC};
      vec[6]  = '{32'h1442FFFF, 0,0,0,        0,0,0,        0,0,0,        32'h22, 32'h22, 32'hFFFFFFFF, 0, 32'hFC};
      vec[7]  = '{32'h14450004, 0,0,0,        0,0,0,        0,0,0,        32'h22, 32'h55, 32'h4,        1, 32'h110};
      vec[8]  = '{32'h34A78001, 0,0,0,        0,0,0,        0,0,0,        32'h55, 32'h0,  32'h8001,     0, 32'h20104};
      vec[9]  = '{32'h8C41FFFC, 0,0,0,        0,0,0,        0,0,0,        32'h22, 32'h0,  32'hFFFFFFFC, 0, 32'hF0};
      vec[10] = '{32'h10000001, 1,0,32'h77,   1,0,32'h66,   0,0,0,        32'h0,  32'h0,  32'h1,        1, 32'h104};
      vec[11] = '{32'h10A60002, 0,0,0,        1,6,32'h55,   0,0,0,        32'h55, 32'h55, 32'h2,        1, 32'h108};

      rst = 0; if_valid = 1; if_inst = 32'h20010005; if_pc4 = 32'h104;
      ext_stall = 0; flush = 0; which_reg = 0;
      fwd_idle();

      // Reset holds state cleared even with a live IF and running clock.
      #22;
      check("rst_inst",   id_inst, 32'h0);
      check("rst_pc4",    id_pc4, 32'h40);
      check("rst_valid",  {31'b0, id_valid}, 32'h0);
      check("rst_br",     {31'b0, br_taken}, 32'h0);
      check("rst_hazard", {31'b0, hazard_stall}, 32'h0);
      check("rst_cnt",    {30'b0, stall_cnt}, 32'h0);
      @(negedge clk);
      rst = 1;

      // First load: addi $1,$0,5.
      step();
      check("ld_valid", {31'b0, id_valid}, 32'h1);
      check("ld_imm",   id_imm, 32'h5);
      check("ld_rs",    {27'b0, rs}, 32'h0);
      check("ld_rt",    {27'b0, rt}, 32'h1);
      check("ld_pc4",   id_pc4, 32'h104);

      // Preload registers through WB.
      if_valid = 0; if_inst = 32'h0;
      wb_wreg = 1; wb_destR = 2; wb_dest = 32'h22;
      step();
      wb_destR = 5; wb_dest = 32'h55;
      step();
      fwd_idle();
      which_reg = 5;
      #1 check("dbg_r5", reg_content, 32'h55);

      // Load-use hazard on add $3,$1,$2.
      if_valid = 1; if_inst = 32'h00221820; if_pc4 = 32'h200;
      step();
      if_inst = 32'h00000020; if_pc4 = 32'h204;
      ex_wreg = 1; ex_m2reg = 1; ex_destR = 1;
      #1;
      check("lu_hazard", {31'b0, hazard_stall}, 32'h1);
      check("lu_valid",  {31'b0, id_valid}, 32'h0);
      check("lu_br",     {31'b0, br_taken}, 32'h0);
      step();
      check("lu_hold_inst", id_inst, 32'h00221820);
      check("lu_hold_pc4",  id_pc4, 32'h200);
      check("lu_cnt",       {30'b0, stall_cnt}, 32'h1);
      ex_m2reg = 0;
      #1;
      check("lu_clear_hazard", {31'b0, hazard_stall}, 32'h0);
      check("lu_clear_valid",  {31'b0, id_valid}, 32'h1);
      step();
      check("lu_pass_inst", id_inst, 32'h00000020);
      check("lu_pass_cnt",  {30'b0, stall_cnt}, 32'h1);
      fwd_idle();

      // Table: load each instruction, then present forwarding sources.
      for (int i = 0; i < 12; i++) begin
         fwd_idle();
         if_valid = 1; if_inst = vec[i].inst; if_pc4 = 32'h100;
         step();
         ex_wreg  = vec[i].ex_w;  ex_destR  = vec[i].ex_d;  ex_alu   = vec[i].ex_v;
         mem_wreg = vec[i].mem_w; mem_destR = vec[i].mem_d; mem_data = vec[i].mem_v;
         wb_wreg  = vec[i].wb_w;  wb_destR  = vec[i].wb_d;  wb_dest  = vec[i].wb_v;
         #1;
         check($sformatf("v%0d_inA", i), id_inA, vec[i].e_a);
         check($sformatf("v%0d_inB", i), id_inB, vec[i].e_b);
         check($sformatf("v%0d_imm", i), id_imm, vec[i].e_imm);
         check($sformatf("v%0d_br",  i), {31'b0, br_taken}, {31'b0, vec[i].e_br});
         check($sformatf("v%0d_tgt", i), br_target, vec[i].e_tgt);
         check($sformatf("v%0d_vld", i), {31'b0, id_valid}, 32'h1);
      end
      fwd_idle();

      // Flush while a load-use hazard is active: flush wins, no count.
      if_inst = 32'h00221820; if_pc4 = 32'h300;
      step();
      ex_wreg = 1; ex_m2reg = 1; ex_destR = 2; flush = 1;
      #1 check("fl_hazard", {31'b0, hazard_stall}, 32'h1);
      step();
      check("fl_inst",  id_inst, 32'h0);
      check("fl_valid", {31'b0, id_valid}, 32'h0);
      check("fl_cnt",   {30'b0, stall_cnt}, 32'h1);
      flush = 0;
      fwd_idle();

      // Saturation: five external stall cycles from count 1.
      if_inst = 32'h20030007; if_pc4 = 32'h400;
      step();
      ext_stall = 1; if_inst = 32'h20040009;
      for (int c = 0; c < 5; c++) step();
      check("sat_cnt",  {30'b0, stall_cnt}, 32'h3);
      check("sat_hold", id_inst, 32'h20030007);
      ext_stall = 0;

      // R0 write ignored; debug port shows stored value only (no bypass).
      wb_wreg = 1; wb_destR = 0; wb_dest = 32'hFFFF;
      step();
      which_reg = 0;
      #1 check("r0_dbg", reg_content, 32'h0);
      wb_destR = 5; wb_dest = 32'h99; which_reg = 5;
      #1 check("dbg_nobypass", reg_content, 32'h55);
      step();
      check("dbg_written", reg_content, 32'h99);
      fwd_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
